// File: rtl/global_variables.sv
// Core-wide widths shared by every pipeline block.
package global_variables;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
endpackage

// File: rtl/structures.sv
// Reservation-station entry types and the CDB wake-up helpers shared by slots and dispatch.
package structures;
    import global_variables::*;

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic [TAG_W-1:0] tag;
        logic             valid;
    } operand_t;

    typedef struct packed {
        logic [7:0]       instr_name;
        logic [XLEN-1:0]  address;
        logic [XLEN-1:0]  immediate;
        logic [TAG_W-1:0] rd_tag;
        logic [3:0]       flags;
        operand_t         src_1;
        operand_t         src_2;
    } rs_entry_t;

    // CDB port 0 is checked first so it wins when both ports carry the same tag.
    function automatic operand_t snoop_operand(
        input operand_t                    op,
        input logic [1:0]                  cdb_valid,
        input logic [1:0][TAG_W-1:0]       cdb_tag,
        input logic [1:0][XLEN-1:0]        cdb_result
    );
        operand_t res;
        res = op;
        if (!op.valid) begin
            if (cdb_valid[0] && cdb_tag[0] == op.tag) begin
                res.value = cdb_result[0];
                res.valid = 1'b1;
            end else if (cdb_valid[1] && cdb_tag[1] == op.tag) begin
                res.value = cdb_result[1];
                res.valid = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic rs_entry_t snoop_entry(
        input rs_entry_t                   e,
        input logic [1:0]                  cdb_valid,
        input logic [1:0][TAG_W-1:0]       cdb_tag,
        input logic [1:0][XLEN-1:0]        cdb_result
    );
        rs_entry_t res;
        res       = e;
        res.src_1 = snoop_operand(e.src_1, cdb_valid, cdb_tag, cdb_result);
        res.src_2 = snoop_operand(e.src_2, cdb_valid, cdb_tag, cdb_result);
        return res;
    endfunction
endpackage

// File: rtl/age_matrix.sv
// Relative-age tracking between slots and one-hot grant of the oldest ready slot.
module age_matrix #(
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc_0,
    input  logic [DEPTH-1:0] alloc_1,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant
);
    // older_q[i][j] set means slot i was allocated before slot j.
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic                        blocked;

    always_comb begin
        older_d = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (free[i]) older_d[i] = '0;
        end
        // Port 0 is applied before port 1 so a same-cycle pair ends up port 0 older.
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_0[i]) begin
                older_d[i] = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != i) older_d[j][i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_1[i]) begin
                older_d[i] = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != i) older_d[j][i] = 1'b1;
                end
            end
        end
        if (flush) older_d = '0;
    end

    always_comb begin
        grant   = '0;
        blocked = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) blocked = 1'b1;
            end
            grant[i] = ready[i] && !blocked;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) older_q <= '0;
        else        older_q <= older_d;
    end
endmodule

// File: rtl/reservation_station.sv
// Dual-issue reservation station with CDB wake-up and an oldest-first registered dispatch port.
module reservation_station
    import structures::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int TAG_W = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [1:0]            issue_valid,
    input  rs_entry_t [1:0]       issue_entry,
    input  logic [1:0]            cdb_valid,
    input  logic [1:0][TAG_W-1:0] cdb_tag,
    input  logic [1:0][XLEN-1:0]  cdb_result,
    output logic                  full,
    output logic                  disp_valid,
    input  logic                  disp_ready,
    output rs_entry_t             disp_entry
);
    rs_entry_t [DEPTH-1:0] slot_q, slot_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic                  full_q, full_d;
    logic                  disp_valid_q, disp_valid_d;
    rs_entry_t             disp_entry_q, disp_entry_d;

    logic [DEPTH-1:0] free_slots, lowest_free, rest_free, second_free;
    logic [DEPTH-1:0] alloc_0, alloc_1, ready, grant, dispatched;
    logic             accept, fire;

    // Issue targets only slots empty before this edge; a clear full flag guarantees two of them.
    always_comb begin
        free_slots  = ~valid_q;
        lowest_free = free_slots & (~free_slots + DEPTH'(1));
        rest_free   = free_slots & ~lowest_free;
        second_free = rest_free & (~rest_free + DEPTH'(1));
        accept      = ~full_q;
        alloc_0     = (issue_valid[0] && accept) ? lowest_free : '0;
        alloc_1     = '0;
        if (issue_valid[1] && accept) alloc_1 = issue_valid[0] ? second_free : lowest_free;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] && slot_q[i].src_1.valid && slot_q[i].src_2.valid;
        end
        fire       = (!disp_valid_q || disp_ready) && (|grant);
        dispatched = fire ? grant : '0;
    end

    age_matrix #(.DEPTH(DEPTH)) u_age_matrix (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .alloc_0 (alloc_0),
        .alloc_1 (alloc_1),
        .free    (dispatched),
        .ready   (ready),
        .grant   (grant)
    );

    always_comb begin
        slot_d       = slot_q;
        valid_d      = (valid_q & ~dispatched) | alloc_0 | alloc_1;
        disp_entry_d = disp_entry_q;
        disp_valid_d = disp_valid_q && !disp_ready;
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = snoop_entry(slot_q[i], cdb_valid, cdb_tag, cdb_result);
            if (alloc_0[i]) slot_d[i] = snoop_entry(issue_entry[0], cdb_valid, cdb_tag, cdb_result);
            if (alloc_1[i]) slot_d[i] = snoop_entry(issue_entry[1], cdb_valid, cdb_tag, cdb_result);
        end
        if (fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[i]) disp_entry_d = slot_q[i];
            end
            disp_valid_d = 1'b1;
        end else if (disp_valid_q) begin
            disp_entry_d = snoop_entry(disp_entry_q, cdb_valid, cdb_tag, cdb_result);
        end
        if (flush) begin
            valid_d      = '0;
            disp_valid_d = 1'b0;
        end
        full_d = ($countones(~valid_d) < 2);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q       <= '0;
            valid_q      <= '0;
            full_q       <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_entry_q <= '0;
        end else begin
            slot_q       <= slot_d;
            valid_q      <= valid_d;
            full_q       <= full_d;
            disp_valid_q <= disp_valid_d;
            disp_entry_q <= disp_entry_d;
        end
    end

    assign full       = full_q;
    assign disp_valid = disp_valid_q;
    assign disp_entry = disp_entry_q;
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 8, number of entry slots (power of two, >= 4).
REQ-003 SHALL have parameter TAG_W, default 6, rename-tag width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous clear on branch mispredict.
REQ-008 issue_valid  input  2  per-port issue strobe; port 0 is older than port 1.
REQ-009 issue_entry  input  2 x rs_entry_t  fields: instr_name, address, immediate, rd tag, flags, and src_1/src_2 each {value XLEN, tag TAG_W, valid}.
REQ-010 cdb_valid  input  2  common-data-bus result strobes.
REQ-011 cdb_tag  input  2 x TAG_W  result tags.
REQ-012 cdb_result  input  2 x XLEN  result values.
REQ-013 full  output  1  fewer than 2 free slots; drives the fullness bus.
REQ-014 disp_valid  output  1  dispatch entry valid to the execution unit.
REQ-015 disp_ready  input  1  execution unit accepts the dispatch entry.
REQ-016 disp_entry  output  rs_entry_t  operand-complete entry.

Function
REQ-017 Each clock edge, every valid issue port SHALL write into a distinct free slot, lowest free index first, port 0 before port 1.
REQ-018 Issue while full=1 SHALL be ignored, with no state change; this is an upstream protocol error.
REQ-019 full SHALL be registered and equal (free slots after this edge < 2).
REQ-020 For each stored entry, each source with valid=0 and tag equal to a cdb_tag[k] with cdb_valid[k]=1 SHALL capture cdb_result[k] and set valid=1 at that edge.
REQ-021 Snoop SHALL also apply to issue_entry operands in their write cycle, with no lost wake-up.
REQ-022 If both CDB ports carry the same tag, port 0 SHALL win.
REQ-023 An entry SHALL be ready when both sources are valid.
REQ-024 Selection SHALL pick the oldest ready entry via an age matrix; issue-cycle order gives port 0 older than port 1.
REQ-025 Dispatch uses an output register: the selected entry SHALL load into disp_entry with disp_valid=1 when disp_valid=0 or (disp_valid and disp_ready).
REQ-026 The selected slot SHALL be freed on that same edge.
REQ-027 disp_entry SHALL hold stable while disp_valid=1 and disp_ready=0.
REQ-028 The dispatch register SHALL snoop the CDB like a slot.
REQ-029 Latency: an entry written operand-complete at edge E SHALL give disp_valid=1 after edge E+1, provided the output register is free.
REQ-030 flush SHALL clear all slot valid bits, the age matrix and disp_valid at the next edge, with priority over issue, CDB and dispatch in that cycle.
REQ-031 Throughput: one dispatch per cycle when disp_ready is held at 1.

Reset
REQ-032 Reset assertion SHALL immediately clear all slot valid bits, the age matrix, disp_valid and full to 0.
REQ-033 disp_entry SHALL reset to all-zero.
REQ-034 Reset mid-operation SHALL discard all held entries; no dispatch SHALL occur until an issue after release.

Structure
REQ-035 rs_entry_t and its operand sub-struct SHALL live in package structures; XLEN SHALL come from global_variables.
REQ-036 The age matrix and oldest-ready select SHALL be a sub-module age_matrix (DEPTH parameter; inputs alloc/free/ready vectors; output one-hot grant).

Verification
REQ-037 Two issues with sources valid, disp_ready=1 -> port-0 entry dispatched at E+1, port-1 entry at E+2.
REQ-038 Issue src_1 tag 5 not valid; two cycles later cdb_tag[1]=5, cdb_result=0xDEADBEEF -> dispatch with src_1 value 0xDEADBEEF one cycle after the CDB edge.
REQ-039 Issue coinciding with a CDB match on its tag in the same cycle -> operand captured, dispatch at E+1.
REQ-040 Fill 7 of 8 slots -> full=1; further issue ignored; one dispatch handshake -> full=0.
REQ-041 disp_ready=0 for 3 cycles -> disp_entry unchanged; flush asserted -> disp_valid=0 and all slots empty next cycle.
REQ-042 Assert reset low mid-stream with 4 entries held -> outputs 0 immediately; after release, no dispatch without a new issue.
